// File: rtl/spk_dect_multi.sv
// Per-channel threshold spike detector with refractory suppression
// and a first-word-fall-through event FIFO with drop counting.
module spk_dect_multi #(
  parameter int N_CH       = 160,
  parameter int CH_W       = 12,
  parameter int DATA_W     = 32,
  parameter int FRAME_W    = 32,
  parameter int HASH_W     = 32,
  parameter int REFRAC_W   = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          polarity,
  input  logic [REFRAC_W-1:0]           refrac_len,
  input  logic                          in_valid,
  input  logic [FRAME_W-1:0]            in_frame,
  input  logic [CH_W-1:0]               in_ch,
  input  logic [HASH_W-1:0]             in_ch_hash,
  input  logic [DATA_W-1:0]             in_thr,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FRAME_W-1:0]            out_frame,
  output logic [CH_W-1:0]               out_ch,
  output logic [HASH_W-1:0]             out_ch_hash,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [CH_W-1:0]    ch;
    logic [HASH_W-1:0]  hash;
    logic [DATA_W-1:0]  data;
  } ev_t;

  logic                s1_vld_q, s1_vld_d;
  ev_t                 s1_ev_q, s1_ev_d;
  logic [DATA_W-1:0]   s1_thr_q, s1_thr_d;
  logic [N_CH-1:0]     below_q, below_d;
  logic [REFRAC_W-1:0] refrac_q [N_CH];
  logic [REFRAC_W-1:0] refrac_d [N_CH];
  ev_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic [15:0]         drop_q, drop_d;

  logic             take, cond, spike;
  logic             full, pop, push;
  logic [IDX_W-1:0] idx;
  ev_t              head;

  assign take = in_valid & en & (32'(in_ch) < N_CH);

  always_comb begin
    s1_vld_d = take;
    s1_ev_d  = s1_ev_q;
    s1_thr_d = s1_thr_q;
    if (take) begin
      s1_ev_d  = '{frame: in_frame, ch: in_ch,
                   hash: in_ch_hash, data: in_data};
      s1_thr_d = in_thr;
    end
  end

  // Arrays are read and written in the same cycle, so a
  // back-to-back sample on one channel sees the fresh update.
  always_comb begin
    idx      = s1_ev_q.ch[IDX_W-1:0];
    cond     = polarity
             ? ($signed(s1_ev_q.data) > $signed(s1_thr_q))
             : ($signed(s1_ev_q.data) < $signed(s1_thr_q));
    spike    = s1_vld_q & cond & ~below_q[idx]
             & (refrac_q[idx] == '0);
    below_d  = below_q;
    refrac_d = refrac_q;
    if (s1_vld_q) begin
      below_d[idx] = cond;
      if (spike)
        refrac_d[idx] = refrac_len;
      else if (refrac_q[idx] != '0)
        refrac_d[idx] = refrac_q[idx] - 1'b1;
    end
  end

  always_comb begin
    out_valid = (lvl_q != '0);
    full      = (lvl_q == LW'(FIFO_DEPTH));
    pop       = out_valid & out_ready;
    push      = spike & (~full | pop);
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    lvl_d     = lvl_q + LW'(push) - LW'(pop);
    drop_d    = drop_q;
    if (spike & ~push & (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  assign head        = mem_q[rd_q];
  assign out_frame   = out_valid ? head.frame : '0;
  assign out_ch      = out_valid ? head.ch    : '0;
  assign out_ch_hash = out_valid ? head.hash  : '0;
  assign out_data    = out_valid ? head.data  : '0;
  assign fifo_level  = lvl_q;
  assign drop_cnt    = drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_ev_q  <= '0;
      s1_thr_q <= '0;
      below_q  <= '0;
      for (int i = 0; i < N_CH; i++)
        refrac_q[i] <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
      drop_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ev_q  <= s1_ev_d;
      s1_thr_q <= s1_thr_d;
      below_q  <= below_d;
      refrac_q <= refrac_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= s1_ev_q;
  end

endmodule

// File: tb/tb_spk_dect_multi.sv
// Bench for spk_dect_multi: directed scenarios plus random
// traffic against a queue-based event model.
module tb_spk_dect_multi;

  localparam int N_CH  = 160;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, polarity, in_valid, out_ready;
  logic [7:0]  refrac_len;
  logic [31:0] in_frame, in_ch_hash, in_thr, in_data;
  logic [11:0] in_ch;
  logic        out_valid;
  logic [31:0] out_frame, out_ch_hash, out_data;
  logic [11:0] out_ch;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  spk_dect_multi dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .polarity(polarity), .refrac_len(refrac_len),
    .in_valid(in_valid), .in_frame(in_frame),
    .in_ch(in_ch), .in_ch_hash(in_ch_hash),
    .in_thr(in_thr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .out_ch(out_ch),
    .out_ch_hash(out_ch_hash), .out_data(out_data),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [31:0] frame;
    logic [11:0] ch;
    logic [31:0] hash;
    logic [31:0] data;
  } ev_t;

  ev_t         q[$];
  bit          mbelow [N_CH];
  int          mref [N_CH];
  bit          pv;
  ev_t         pe;
  logic [31:0] pthr;
  int          mdrop;
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  int          frame_n = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N_CH; i++) begin
      mbelow[i] = 0;
      mref[i]   = 0;
    end
    pv    = 0;
    mdrop = 0;
  endtask

  // Advance the model across one rising edge using the
  // inputs that are stable right now.
  task automatic model_edge();
    bit c, spk, pop;
    int ch;
    pop = (q.size() > 0) && out_ready;
    spk = 0;
    if (pv) begin
      ch = int'(pe.ch);
      c  = polarity ? ($signed(pe.data) > $signed(pthr))
                    : ($signed(pe.data) < $signed(pthr));
      spk = c && !mbelow[ch] && (mref[ch] == 0);
      if (spk)              mref[ch] = int'(refrac_len);
      else if (mref[ch] > 0) mref[ch] = mref[ch] - 1;
      mbelow[ch] = c;
    end
    if (pop) void'(q.pop_front());
    if (spk) begin
      if (q.size() < DEPTH) q.push_back(pe);
      else if (mdrop < 65535) mdrop++;
    end
    pv = in_valid && en && (int'(in_ch) < N_CH);
    if (pv) begin
      pe.frame = in_frame;
      pe.ch    = in_ch;
      pe.hash  = in_ch_hash;
      pe.data  = in_data;
      pthr     = in_thr;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("drop_cnt", drop_cnt, mdrop);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_ch", out_ch, q[0].ch);
      chk("out_hash", out_ch_hash, q[0].hash);
      chk("out_frame", out_frame, q[0].frame);
    end
    if (out_valid && out_ready) pops++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic sample(input int ch, input int fr,
                        input int thr, input int d);
    in_valid   = 1'b1;
    in_ch      = 12'(ch);
    in_frame   = fr;
    in_thr     = thr;
    in_data    = d;
    in_ch_hash = $urandom;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int t1[5] = '{0, -150, -200, 0, -150};
  int p0;

  initial begin
    rst_n = 1'b1;
    en = 1'b1; polarity = 1'b0; refrac_len = 8'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_frame = '0; in_ch = '0; in_ch_hash = '0;
    in_thr = '0; in_data = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("init_valid", out_valid, 0);
    chk("init_level", fifo_level, 0);
    chk("init_drop", drop_cnt, 0);
    chk("init_frame", out_frame, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // negative crossings, no refractory
    p0 = pops;
    foreach (t1[i]) sample(3, i, -100, t1[i]);
    idle(3);
    chk("t1_events", pops - p0, 2);

    // refractory of 3 samples
    refrac_len = 8'd3;
    p0 = pops;
    for (int i = 0; i < 10; i++)
      sample(5, 10 + i, -100, (i % 2 == 0) ? -150 : 0);
    idle(3);
    chk("t2_events", pops - p0, 3);
    refrac_len = 8'd0;

    // two channels interleaved within the same frames
    p0 = pops;
    for (int f = 0; f < 4; f++) begin
      sample(0, 100 + f, -100, (f % 2 == 0) ? -150 : 0);
      sample(1, 100 + f, -100, (f % 2 == 0) ? -170 : 0);
    end
    idle(3);
    chk("t3_events", pops - p0, 4);

    // back-pressure: 20 spikes into a 16-deep FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      sample(20 + i, 200 + i, -100, -150);
    idle(2);
    chk("t4_level", fifo_level, 16);
    chk("t4_drop", drop_cnt, 4);
    out_ready = 1'b1;
    idle(20);

    // positive polarity, strict compare, bad channel
    polarity = 1'b1;
    p0 = pops;
    sample(7, 300, 100, 99);
    sample(7, 301, 100, 100);
    sample(7, 302, 100, 101);
    sample(N_CH, 303, 100, 500);
    idle(3);
    chk("t5_events", pops - p0, 1);
    polarity = 1'b0;

    // reset with events pending
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++)
      sample(40 + i, 400 + i, -100, -150);
    idle(2);
    chk("t6_level", fifo_level, 7);
    do_reset();
    out_ready = 1'b1;
    sample(40, 500, -100, -150);
    tick();
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 32'hFFFFFF6A);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r, thr;
      en = ($urandom_range(0, 9) != 0);
      out_ready = (i < 1200) ? ($urandom_range(0, 7) == 0)
                             : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) polarity = ~polarity;
      if ($urandom_range(0, 31) == 0)
        refrac_len = 8'($urandom_range(0, 4));
      r   = int'($urandom_range(0, 19));
      thr = int'($urandom_range(0, 200)) - 100;
      in_valid   = ($urandom_range(0, 4) != 0);
      in_ch      = (r < 18) ? 12'(r % 6)
                 : (r == 18) ? 12'(N_CH) : 12'hFFF;
      in_frame   = frame_n++;
      in_ch_hash = $urandom;
      in_thr     = thr;
      in_data    = thr + int'($urandom_range(0, 40)) - 20;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
